// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath slice:
// data width and ALU opcode encodings.
package datapath_pkg;

   localparam int DW = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SHR  = 4'd4;
   localparam logic [3:0] ALU_SHRA = 4'd5;
   localparam logic [3:0] ALU_SHL  = 4'd6;
   localparam logic [3:0] ALU_ROR  = 4'd7;
   localparam logic [3:0] ALU_ROL  = 4'd8;
   localparam logic [3:0] ALU_MUL  = 4'd9;
   localparam logic [3:0] ALU_DIV  = 4'd10;
   localparam logic [3:0] ALU_NEG  = 4'd11;
   localparam logic [3:0] ALU_NOT  = 4'd12;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU producing a 64-bit {hi, lo} result
// from the RA/RB operand pair.
module alu
   import datapath_pkg::*;
(
   input  logic [3:0]      op_i,
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   output logic [2*DW-1:0] res_o
);

   logic [4:0]             sh;
   logic [2*DW-1:0]        rot_r;
   logic [2*DW-1:0]        rot_l;
   logic signed [2*DW-1:0] prod;
   logic signed [DW-1:0]   quo;
   logic signed [DW-1:0]   rem;
   logic [DW-1:0]          sra;

   assign sh    = b_i[4:0];
   assign rot_r = {a_i, a_i} >> sh;
   assign rot_l = {a_i, a_i} << sh;
   assign sra   = $unsigned($signed(a_i) >>> sh);
   assign prod  = $signed({{DW{a_i[DW-1]}}, a_i})
                * $signed({{DW{b_i[DW-1]}}, b_i});
   assign quo   = $signed(a_i) / $signed(b_i);
   assign rem   = $signed(a_i) % $signed(b_i);

   always_comb begin
      res_o = {{DW{1'b0}}, b_i};
      case (op_i)
         ALU_ADD:  res_o = {{DW{1'b0}}, a_i + b_i};
         ALU_SUB:  res_o = {{DW{1'b0}}, a_i - b_i};
         ALU_AND:  res_o = {{DW{1'b0}}, a_i & b_i};
         ALU_OR:   res_o = {{DW{1'b0}}, a_i | b_i};
         ALU_SHR:  res_o = {{DW{1'b0}}, a_i >> sh};
         ALU_SHRA: res_o = {{DW{1'b0}}, sra};
         ALU_SHL:  res_o = {{DW{1'b0}}, a_i << sh};
         ALU_ROR:  res_o = {{DW{1'b0}}, rot_r[DW-1:0]};
         ALU_ROL:  res_o = {{DW{1'b0}}, rot_l[2*DW-1:DW]};
         ALU_MUL:  res_o = prod;
         ALU_DIV: begin
            // divide by zero: all-ones quotient, dividend as remainder
            if (b_i == '0)
               res_o = {a_i, {DW{1'b1}}};
            else
               res_o = {rem, quo};
         end
         ALU_NEG:  res_o = {{DW{1'b0}}, -a_i};
         ALU_NOT:  res_o = {{DW{1'b0}}, ~a_i};
         default:  res_o = {{DW{1'b0}}, b_i};
      endcase
   end

endmodule

// File: rtl/datapath.sv
// Multi-cycle CPU datapath: register file, PC, operand and
// result registers around a single combinational ALU.
module datapath
   import datapath_pkg::*;
(
   input  logic          iClk,
   input  logic          nRst,
   input  logic [DW-1:0] iMemData,
   output logic [DW-1:0] oMemAddr,
   output logic [DW-1:0] oMemData,
   input  logic          iPC_nRst,
   input  logic          iPC_en,
   input  logic          iPC_jmp,
   input  logic          iPC_loadRA,
   input  logic          iPC_loadImm,
   input  logic          iRF_Write,
   input  logic [3:0]    iRF_AddrA,
   input  logic [3:0]    iRF_AddrB,
   input  logic [3:0]    iRF_AddrC,
   input  logic          iRWB_en,
   input  logic          iRA_en,
   input  logic          iRB_en,
   input  logic          iRZH_en,
   input  logic          iRZL_en,
   input  logic          iRAS_en,
   input  logic [3:0]    iALU_Ctrl,
   input  logic          iMUX_BIS,
   input  logic          iMUX_RZHS,
   input  logic          iMUX_WBM,
   input  logic          iMUX_WBP,
   input  logic          iMUX_MAP,
   input  logic          iMUX_ASS,
   input  logic [DW-1:0] iImm32,
   output logic          oJ_zero,
   output logic          oJ_nZero,
   output logic          oJ_pos,
   output logic          oJ_neg,
   output logic          oALU_zero,
   output logic          oALU_neg
);

   logic [DW-1:0]   rf_q [16];
   logic [DW-1:0]   pc_q,  pc_d;
   logic [DW-1:0]   ra_q,  ra_d;
   logic [DW-1:0]   rb_q,  rb_d;
   logic [DW-1:0]   rzh_q, rzh_d;
   logic [DW-1:0]   rzl_q, rzl_d;
   logic [DW-1:0]   ras_q, ras_d;
   logic [DW-1:0]   rwb_q, rwb_d;
   logic [DW-1:0]   rf_a;
   logic [DW-1:0]   rf_b;
   logic [DW-1:0]   rz_sel;
   logic [2*DW-1:0] alu_res;

   assign rf_a   = rf_q[iRF_AddrA];
   assign rf_b   = rf_q[iRF_AddrB];
   assign rz_sel = iMUX_RZHS ? rzh_q : rzl_q;

   alu u_alu (
      .op_i  (iALU_Ctrl),
      .a_i   (ra_q),
      .b_i   (rb_q),
      .res_o (alu_res)
   );

   always_comb begin
      ra_d  = iRA_en  ? rf_a : ra_q;
      rzh_d = iRZH_en ? alu_res[2*DW-1:DW] : rzh_q;
      rzl_d = iRZL_en ? alu_res[DW-1:0] : rzl_q;
      ras_d = iRAS_en ? rz_sel : ras_q;
      rb_d  = rb_q;
      if (iRB_en)
         rb_d = iMUX_BIS ? iImm32 : rf_b;
   end

   always_comb begin
      rwb_d = rwb_q;
      if (iRWB_en) begin
         if (iMUX_WBM)
            rwb_d = iMemData;
         else if (iMUX_WBP)
            rwb_d = pc_q;
         else if (iMUX_ASS)
            rwb_d = ras_q;
         else
            rwb_d = rz_sel;
      end
   end

   // the PC-local clear outranks the PC enable
   always_comb begin
      pc_d = pc_q;
      if (!iPC_nRst)
         pc_d = '0;
      else if (iPC_en) begin
         if (iPC_loadRA)
            pc_d = ra_q;
         else if (iPC_loadImm && iPC_jmp)
            pc_d = pc_q + 32'd1 + iImm32;
         else
            pc_d = pc_q + 32'd1;
      end
   end

   always_ff @(posedge iClk) begin
      if (nRst) begin
         pc_q  <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
         rzh_q <= '0;
         rzl_q <= '0;
         ras_q <= '0;
         rwb_q <= '0;
         for (int i = 0; i < 16; i++)
            rf_q[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         ra_q  <= ra_d;
         rb_q  <= rb_d;
         rzh_q <= rzh_d;
         rzl_q <= rzl_d;
         ras_q <= ras_d;
         rwb_q <= rwb_d;
         if (iRF_Write)
            rf_q[iRF_AddrC] <= rwb_q;
      end
   end

   assign oMemAddr  = iMUX_MAP ? pc_q : rzl_q;
   assign oMemData  = rb_q;
   assign oALU_zero = (alu_res[DW-1:0] == '0);
   assign oALU_neg  = alu_res[DW-1];
   assign oJ_zero   = (ra_q == '0);
   assign oJ_nZero  = (ra_q != '0);
   assign oJ_pos    = ~ra_q[DW-1];
   assign oJ_neg    = ra_q[DW-1];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: reference model checked every
// cycle plus hand-computed literal expectations.
module tb_datapath;

   logic        iClk = 0;
   logic        nRst;
   logic [31:0] iMemData, oMemAddr, oMemData, iImm32;
   logic        iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
   logic        iRF_Write;
   logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC, iALU_Ctrl;
   logic        iRWB_en, iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
   logic        iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP;
   logic        iMUX_MAP, iMUX_ASS;
   logic        oJ_zero, oJ_nZero, oJ_pos, oJ_neg;
   logic        oALU_zero, oALU_neg;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 0;

   logic [31:0] m_rf [16];
   logic [31:0] m_pc, m_ra, m_rb, m_rzh, m_rzl, m_ras, m_rwb;

   always #5 iClk = ~iClk;

   datapath dut (
      .iClk(iClk), .nRst(nRst),
      .iMemData(iMemData), .oMemAddr(oMemAddr), .oMemData(oMemData),
      .iPC_nRst(iPC_nRst), .iPC_en(iPC_en), .iPC_jmp(iPC_jmp),
      .iPC_loadRA(iPC_loadRA), .iPC_loadImm(iPC_loadImm),
      .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA),
      .iRF_AddrB(iRF_AddrB), .iRF_AddrC(iRF_AddrC),
      .iRWB_en(iRWB_en), .iRA_en(iRA_en), .iRB_en(iRB_en),
      .iRZH_en(iRZH_en), .iRZL_en(iRZL_en), .iRAS_en(iRAS_en),
      .iALU_Ctrl(iALU_Ctrl),
      .iMUX_BIS(iMUX_BIS), .iMUX_RZHS(iMUX_RZHS),
      .iMUX_WBM(iMUX_WBM), .iMUX_WBP(iMUX_WBP),
      .iMUX_MAP(iMUX_MAP), .iMUX_ASS(iMUX_ASS),
      .iImm32(iImm32),
      .oJ_zero(oJ_zero), .oJ_nZero(oJ_nZero),
      .oJ_pos(oJ_pos), .oJ_neg(oJ_neg),
      .oALU_zero(oALU_zero), .oALU_neg(oALU_neg)
   );

   // arithmetic meaning of each opcode, result as {hi, lo}
   function automatic logic [63:0] m_alu(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      int s;
      longint sa, sb, p, q, r;
      logic [31:0] lo;
      s  = int'(b[4:0]);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lo = b;
      case (op)
         4'd0:  lo = a + b;
         4'd1:  lo = a - b;
         4'd2:  lo = a & b;
         4'd3:  lo = a | b;
         4'd4:  lo = a >> s;
         4'd5:  lo = a[31] ? ~((~a) >> s) : (a >> s);
         4'd6:  lo = a << s;
         4'd7:  lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
         4'd8:  lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
         4'd9: begin
            p = sa * sb;
            return p;
         end
         4'd10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd11: lo = 32'd0 - a;
         4'd12: lo = ~a;
         default: lo = b;
      endcase
      return {32'd0, lo};
   endfunction

   function automatic void check(input string name,
                                 input logic [31:0] got,
                                 input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endfunction

   // model state advances on the same edge as the design
   always @(posedge iClk) begin
      logic [63:0] z;
      logic [31:0] rfa, rfb, sel, nrwb, npc;
      z   = m_alu(iALU_Ctrl, m_ra, m_rb);
      rfa = m_rf[iRF_AddrA];
      rfb = m_rf[iRF_AddrB];
      sel = iMUX_RZHS ? m_rzh : m_rzl;
      nrwb = m_rwb;
      if (iRWB_en)
         nrwb = iMUX_WBM ? iMemData : iMUX_WBP ? m_pc :
                iMUX_ASS ? m_ras : sel;
      npc = m_pc;
      if (!iPC_nRst) npc = 0;
      else if (iPC_en)
         npc = iPC_loadRA ? m_ra :
               (iPC_loadImm && iPC_jmp) ? m_pc + 1 + iImm32 : m_pc + 1;
      if (nRst) begin
         for (int i = 0; i < 16; i++) m_rf[i] = 0;
         m_pc = 0; m_ra = 0; m_rb = 0; m_rzh = 0;
         m_rzl = 0; m_ras = 0; m_rwb = 0;
      end else begin
         if (iRF_Write) m_rf[iRF_AddrC] = m_rwb;
         if (iRA_en) m_ra = rfa;
         if (iRB_en) m_rb = iMUX_BIS ? iImm32 : rfb;
         if (iRZH_en) m_rzh = z[63:32];
         if (iRZL_en) m_rzl = z[31:0];
         if (iRAS_en) m_ras = sel;
         m_rwb = nrwb;
         m_pc  = npc;
      end
   end

   always @(negedge iClk) begin
      logic [63:0] z;
      if (chk_en) begin
         z = m_alu(iALU_Ctrl, m_ra, m_rb);
         check("model memaddr", oMemAddr, iMUX_MAP ? m_pc : m_rzl);
         check("model memdata", oMemData, m_rb);
         check("model flags",
               {26'd0, oJ_zero, oJ_nZero, oJ_pos, oJ_neg,
                oALU_zero, oALU_neg},
               {26'd0, m_ra == 0, m_ra != 0, ~m_ra[31], m_ra[31],
                z[31:0] == 0, z[31]});
      end
   end

   task automatic idle();
      nRst = 0; iMemData = 0; iImm32 = 0;
      iPC_nRst = 1; iPC_en = 0; iPC_jmp = 0;
      iPC_loadRA = 0; iPC_loadImm = 0;
      iRF_Write = 0; iRF_AddrA = 0; iRF_AddrB = 0; iRF_AddrC = 0;
      iRWB_en = 0; iRA_en = 0; iRB_en = 0;
      iRZH_en = 0; iRZL_en = 0; iRAS_en = 0; iALU_Ctrl = 0;
      iMUX_BIS = 0; iMUX_RZHS = 0; iMUX_WBM = 0;
      iMUX_WBP = 0; iMUX_MAP = 0; iMUX_ASS = 0;
   endtask

   task automatic tick();
      @(posedge iClk);
      #2;
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [31:0] v);
      idle(); iMemData = v; iMUX_WBM = 1; iRWB_en = 1; tick();
      idle(); iRF_Write = 1; iRF_AddrC = r; tick();
      idle();
   endtask

   task automatic write_rwb(input logic [3:0] r);
      idle(); iRF_Write = 1; iRF_AddrC = r; tick(); idle();
   endtask

   task automatic peek(input logic [3:0] r, input logic [31:0] exp,
                       input string name);
      idle(); iRF_AddrB = r; iRB_en = 1; tick();
      check(name, oMemData, exp);
      idle();
   endtask

   task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
      idle(); iRF_AddrA = a; iRF_AddrB = b;
      iRA_en = 1; iRB_en = 1; tick(); idle();
   endtask

   task automatic run_op(input logic [3:0] op);
      idle(); iALU_Ctrl = op; iRZH_en = 1; iRZL_en = 1; tick();
   endtask

   initial begin
      idle();
      nRst = 1;
      tick();
      chk_en = 1;
      tick();
      idle(); #1;
      check("reset memaddr", oMemAddr, 32'h0);
      check("reset memdata", oMemData, 32'h0);
      check("reset j_zero", {31'd0, oJ_zero}, 32'd1);
      check("reset alu_zero", {31'd0, oALU_zero}, 32'd1);

      load_reg(3, 32'hFE00_0022);
      load_reg(7, 32'h0000_0024);
      load_reg(4, 32'h0000_0028);
      peek(4, 32'h28, "rf r4 load");
      load_ab(3, 7);
      run_op(4'd8);
      check("rol rzl", oMemAddr, 32'hE000_022F);
      idle(); iRWB_en = 1; tick();
      write_rwb(4);
      peek(4, 32'hE000_022F, "rol r4");

      idle(); iMUX_MAP = 1; iPC_en = 1; tick();
      idle(); iMUX_MAP = 1; #1;
      check("pc fetch", oMemAddr, 32'h1);

      load_reg(5, 32'd5);
      idle(); iRF_AddrA = 5; iRA_en = 1; iRB_en = 1;
      iMUX_BIS = 1; iImm32 = 32'hFFFF_FFFF; tick();
      idle(); #1;
      check("imm add alu_zero", {31'd0, oALU_zero}, 32'd0);
      iRZL_en = 1; tick();
      check("imm add rzl", oMemAddr, 32'd4);

      load_reg(1, 32'hFFFF_FFF9);
      load_reg(2, 32'd2);
      load_ab(1, 2);
      run_op(4'd10);
      check("div quotient", oMemAddr, 32'hFFFF_FFFD);
      idle(); iMUX_RZHS = 1; iRAS_en = 1; tick();
      idle(); iMUX_ASS = 1; iRWB_en = 1; tick();
      write_rwb(6);
      peek(6, 32'hFFFF_FFFF, "div remainder");
      idle(); iRB_en = 1; iMUX_BIS = 1; iImm32 = 0; tick();
      run_op(4'd10);
      check("div0 quotient", oMemAddr, 32'hFFFF_FFFF);
      idle(); iMUX_RZHS = 1; iRWB_en = 1; tick();
      write_rwb(8);
      peek(8, 32'hFFFF_FFF9, "div0 remainder");

      load_ab(1, 2);
      run_op(4'd9);
      check("mul lo", oMemAddr, 32'hFFFF_FFF2);
      check("mul alu_neg", {31'd0, oALU_neg}, 32'd1);
      idle(); iMUX_RZHS = 1; iRWB_en = 1; tick();
      write_rwb(12);
      peek(12, 32'hFFFF_FFFF, "mul hi");

      load_reg(9, 32'd10);
      idle(); iRF_AddrA = 9; iRA_en = 1; tick();
      idle(); iPC_en = 1; iPC_loadRA = 1; tick();
      idle(); iRF_AddrA = 0; iRA_en = 1; tick();
      idle(); #1;
      check("branch j_zero", {31'd0, oJ_zero}, 32'd1);
      check("branch j_nzero", {31'd0, oJ_nZero}, 32'd0);
      iPC_en = 1; iPC_loadImm = 1; iPC_jmp = 1; iImm32 = 4; tick();
      idle(); iMUX_MAP = 1; #1;
      check("branch pc", oMemAddr, 32'd15);
      idle(); iMUX_WBP = 1; iRWB_en = 1; tick();
      write_rwb(10);
      peek(10, 32'd15, "pc writeback");
      idle(); iPC_en = 1; iPC_loadImm = 1; iImm32 = 4; tick();
      idle(); iMUX_MAP = 1; #1;
      check("no jmp pc", oMemAddr, 32'd16);

      load_ab(3, 7);
      for (int op = 0; op < 16; op++) run_op(4'(op));
      load_ab(1, 9);
      for (int op = 0; op < 13; op++) run_op(4'(op));

      idle(); iMemData = 32'hDEAD_BEEF; iMUX_WBM = 1; iRWB_en = 1;
      iRF_Write = 1; iRF_AddrC = 5; nRst = 1; tick();
      idle(); iMUX_MAP = 1; #1;
      check("reset pc", oMemAddr, 32'd0);
      write_rwb(3);
      for (int r = 0; r < 16; r++) peek(4'(r), 32'd0, "reset rf");

      idle(); tick();
      chk_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL use a single clock, iClk (input, 1 bit); all state updates occur on the rising edge of iClk.
REQ-002 nRst SHALL be an input of 1 bit: a synchronous, active-high reset, sampled on the iClk rising edge.
REQ-003 The memory ports SHALL be:
- iMemData, input, 32 bits, memory read data.
- oMemAddr, output, 32 bits, memory address.
- oMemData, output, 32 bits, memory write data.
REQ-004 The program counter controls SHALL be 1-bit inputs: iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm.
REQ-005 The register file ports SHALL be iRF_Write (input, 1 bit) plus iRF_AddrA, iRF_AddrB and iRF_AddrC (inputs, 4 bits each).
REQ-006 The register enables SHALL be 1-bit inputs: iRWB_en, iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en.
REQ-007 iALU_Ctrl SHALL be a 4-bit input selecting the ALU opcode.
REQ-008 The multiplexer selects SHALL be 1-bit inputs: iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS.
REQ-009 iImm32 SHALL be a 32-bit input carrying the immediate value.
REQ-010 The status outputs SHALL be 1-bit: oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_zero, oALU_neg.

Function
REQ-011 Register file: 16 registers of 32 bits each.
- Read ports A and B are combinational.
- When iRF_Write=1, RF[iRF_AddrC] is loaded from RWB on the clock edge.
- On a simultaneous read and write of the same register, the read returns the old value.
REQ-012 RA SHALL load RF port A when iRA_en=1; otherwise it holds.
REQ-013 RB SHALL load (iMUX_BIS ? iImm32 : RF port B) when iRB_en=1; otherwise it holds.
REQ-014 The ALU is combinational on RA and RB and produces a 64-bit result {hi, lo}. For every op that is not MUL or DIV, hi=0. Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL (signed, 64-bit), 10 DIV (signed: lo=quotient, hi=remainder), 11 NEG, 12 NOT.
- Codes 13-15 pass RB through to lo.
REQ-015 Shift and rotate amount SHALL be RB[4:0].
REQ-016 ADD and SUB SHALL wrap modulo 2^32.
REQ-017 DIV by zero SHALL give lo=32'hFFFFFFFF and hi=RA.
REQ-018 RZH SHALL load ALU hi when iRZH_en=1, and RZL SHALL load ALU lo when iRZL_en=1.
REQ-019 RAS SHALL load (iMUX_RZHS ? RZH : RZL) when iRAS_en=1.
REQ-020 RWB SHALL load on iRWB_en=1, with source priority:
1. iMUX_WBM=1 gives iMemData.
2. Else iMUX_WBP=1 gives PC.
3. Else iMUX_ASS=1 gives RAS.
4. Else (iMUX_RZHS ? RZH : RZL).
REQ-021 PC:
- The PC is 32 bits.
- iPC_nRst=0 clears the PC synchronously; this has priority over iPC_en.
- Otherwise, when iPC_en=1:
  - iPC_loadRA=1 gives PC<=RA.
  - Else iPC_loadImm=1 and iPC_jmp=1 gives PC<=PC+1+iImm32.
  - Else PC<=PC+1.
REQ-022 PC arithmetic SHALL wrap modulo 2^32.
REQ-023 oMemAddr SHALL be iMUX_MAP ? PC : RZL.
REQ-024 oMemData SHALL be RB.
REQ-025 oALU_zero SHALL be (ALU lo==0) and oALU_neg SHALL be ALU lo[31]; both are combinational.
REQ-026 The jump flags are combinational on RA:
- oJ_zero = (RA==0).
- oJ_nZero = (RA!=0).
- oJ_pos = ~RA[31].
- oJ_neg = RA[31].

Reset
REQ-027 While nRst=1 at a clock edge, the PC, RA, RB, RZH, RZL, RAS, RWB and all 16 RF registers SHALL clear to 0.
REQ-028 nRst SHALL override all enables; asserting it mid-operation discards any in-flight result.
REQ-029 Out of reset, all outputs SHALL follow from the cleared state: oMemAddr=0, oMemData=0, oJ_zero=1, oALU_zero=1 (with iALU_Ctrl=0).

Structure
REQ-030 A shared package SHALL hold the ALU opcode localparams (0-12) and the data width (32).
REQ-031 The ALU SHALL be one combinational sub-module named alu; the register file, the PC and the pipeline registers stay inline.

Verification
REQ-032 ROL: load R3=32'hFE000022, R7=32'h24 and R4=32'h28 through WBM->RWB->RF; then A=3, B=7, RA/RB load, op ROL, RZ load, RWB load, write C=4 -> R4=32'hE000022F.
REQ-033 PC fetch: with iPC_nRst=1, iPC_en=1 for 1 cycle and iMUX_MAP=1 -> PC goes 0 to 1, and oMemAddr=1 in the next cycle.
REQ-034 Immediate ADD: RA=5, iMUX_BIS=1, iImm32=32'hFFFFFFFF, op ADD -> RZL=4 and oALU_zero=0.
REQ-035 DIV: RA=-7, RB=2 -> RZL=-3 and RZH=-1; with RB=0 -> RZL=32'hFFFFFFFF and RZH=-7.
REQ-036 Branch: RA=0 -> oJ_zero=1; iPC_loadImm=1, iPC_jmp=1, iImm32=4, PC=10 -> PC=15.
REQ-037 Reset mid-operation: assert nRst during a pending RWB load -> RWB=0, PC=0, and all RF registers read 0.
